// File: rtl/func_pkg.sv
// rtl/func_pkg.sv - shared state encoding, clog2 helper and timeout counter width for func_scheduler
package func_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  // Wide enough for the largest supported TMO (255).
  localparam int CNT_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with asynchronous clear
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/func_scheduler.sv
// rtl/func_scheduler.sv - round-robin four-phase scheduler for a shared function resource with done timeout
module func_scheduler
  import func_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int TMO = 16,
  localparam int GW  = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  ack,
  output logic [N-1:0]  sel,
  output logic          start,
  input  logic          done,
  output logic [GW-1:0] gid,
  output logic          busy,
  output logic          err
);

  logic [N-1:0] req_s;
  logic         done_s;

  for (genvar i = 0; i < N; i++) begin : g_req_sync
    sync2 u_sync_req (.clk(clk), .rst(rst), .d(req[i]), .q(req_s[i]));
  end
  sync2 u_sync_done (.clk(clk), .rst(rst), .d(done), .q(done_s));

  state_e           state_q, state_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
  logic [N-1:0]  rot;
  logic [GW-1:0] off;
  logic          pick_vld;
  logic [GW:0]   sum;
  logic [GW-1:0] pick;
  logic [GW-1:0] gid_nxt;
  logic [N-1:0]  gid_oh;

  always_comb begin
    rot      = N'({req_s, req_s} >> ptr_q);
    off      = '0;
    pick_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off      = GW'(i);
        pick_vld = 1'b1;
      end
    end
    sum  = {1'b0, ptr_q} + {1'b0, off};
    pick = (sum >= (GW+1)'(N)) ? GW'(sum - (GW+1)'(N)) : GW'(sum);
  end

  assign gid_nxt = (gid_q == GW'(N - 1)) ? '0 : gid_q + 1'b1;
  assign gid_oh  = N'(1) << gid_q;

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A resource still showing done has not returned to zero yet.
        if (pick_vld && !done_s) begin
          gid_d   = pick;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_s) begin
          state_d = ST_ACK;
        end else if (cnt_q == CNT_W'(TMO - 1)) begin
          err     = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (!req_s[gid_q]) begin
          ptr_d   = gid_nxt;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  assign start = (state_q == ST_ISSUE);
  assign busy  = (state_q != ST_IDLE);
  assign sel   = (state_q != ST_IDLE) ? gid_oh : '0;
  assign ack   = (state_q == ST_ACK) ? gid_oh : '0;
  assign gid   = gid_q;

endmodule

// File: tb/tb_func_scheduler.sv
// tb/tb_func_scheduler.sv - directed self-checking bench for func_scheduler
module tb_func_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] ack;
  logic [3:0] sel;
  logic       start;
  logic       done;
  logic [1:0] gid;
  logic       busy;
  logic       err;

  int n_cmp;
  int n_bad;

  func_scheduler #(.N(4), .TMO(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .ack  (ack),
    .sel  (sel),
    .start(start),
    .done (done),
    .gid  (gid),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(input string tag);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 64 && !hit; k++) begin
      tick(1);
      if (start) hit = 1'b1;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_ack(input string tag);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 64 && !hit; k++) begin
      tick(1);
      if (ack != 4'b0000) hit = 1'b1;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 64 && !hit; k++) begin
      tick(1);
      if (!busy) hit = 1'b1;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  always @(negedge clk) begin
    n_cmp++;
    assert ($onehot0(sel) && $onehot0(ack)) else begin
      n_bad++;
      $error("FAIL onehot0 observed sel=%b ack=%b expected at most one bit each", sel, ack);
    end
  end

  initial begin
    bit      early;
    int      seen;
    logic [1:0] g;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;

    tick(2);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_gid", 32'(gid), 32'h0);
    rst = 1'b0;
    tick(1);

    // Single request 0010, done three cycles after start.
    req = 4'b0010;
    tick(2);
    chk("t1_sync_busy", 32'(busy), 32'h0);
    tick(1);
    chk("t1_start", 32'(start), 32'h1);
    chk("t1_sel", 32'(sel), 32'h2);
    chk("t1_gid", 32'(gid), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    tick(1);
    chk("t1_start_pulse", 32'(start), 32'h0);
    chk("t1_sel_hold", 32'(sel), 32'h2);
    tick(1);
    done = 1'b1;
    tick(2);
    chk("t1_ack_early", 32'(ack), 32'h0);
    tick(1);
    chk("t1_ack", 32'(ack), 32'h2);
    req  = 4'b0000;
    done = 1'b0;
    tick(2);
    chk("t1_ack_hold", 32'(ack), 32'h2);
    tick(1);
    chk("t1_ack_clr", 32'(ack), 32'h0);
    chk("t1_sel_clr", 32'(sel), 32'h0);
    chk("t1_busy_clr", 32'(busy), 32'h0);

    // Round robin with all four requesting; reset first so the scan starts at 0.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = 2'(k % 4);
      wait_start("rr_start");
      chk("rr_gid", 32'(gid), 32'(g));
      done = 1'b1;
      wait_ack("rr_ack_wait");
      chk("rr_ack", 32'(ack), 32'(4'b0001 << g));
      req[g] = 1'b0;
      done   = 1'b0;
      wait_idle("rr_idle");
      if (k < 4) req[g] = 1'b1;
    end
    req = 4'b0000;
    tick(4);

    // Timeout: ptr is 1, request 2 never completes.
    req = 4'b0100;
    wait_start("tmo_start");
    chk("tmo_gid", 32'(gid), 32'h2);
    early = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick(1);
      if (err) early = 1'b1;
    end
    chk("tmo_err_early", 32'(early), 32'h0);
    tick(1);
    chk("tmo_err", 32'(err), 32'h1);
    tick(1);
    chk("tmo_err_once", 32'(err), 32'h0);
    chk("tmo_ack", 32'(ack), 32'h4);
    req = 4'b0000;
    wait_idle("tmo_idle");

    // done still high blocks the next grant.
    req = 4'b0001;
    wait_start("dh_start");
    chk("dh_gid0", 32'(gid), 32'h0);
    done = 1'b1;
    wait_ack("dh_ack_wait");
    req = 4'b0000;
    wait_idle("dh_idle");
    req  = 4'b0001;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (start || busy) seen++;
    end
    chk("dh_blocked", 32'(seen), 32'h0);
    done = 1'b0;
    tick(2);
    chk("dh_still_idle", 32'(busy), 32'h0);
    tick(1);
    chk("dh_start_late", 32'(start), 32'h1);
    chk("dh_gid", 32'(gid), 32'h0);
    done = 1'b1;
    wait_ack("dh_ack2_wait");
    req  = 4'b0000;
    done = 1'b0;
    wait_idle("dh_idle2");

    // Reset during WAIT; ptr is 1 so 1001 grants 3, after reset it must grant 0.
    req = 4'b1001;
    wait_start("rw_start");
    chk("rw_gid", 32'(gid), 32'h3);
    tick(2);
    rst = 1'b1;
    #1;
    chk("rw_ack", 32'(ack), 32'h0);
    chk("rw_sel", 32'(sel), 32'h0);
    chk("rw_busy", 32'(busy), 32'h0);
    chk("rw_err", 32'(err), 32'h0);
    tick(2);
    rst = 1'b0;
    wait_start("rw_start2");
    chk("rw_gid2", 32'(gid), 32'h0);
    done = 1'b1;
    wait_ack("rw_ack_wait");
    req  = 4'b0000;
    done = 1'b0;
    wait_idle("rw_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/func_scheduler.md
FUNC_SCHEDULER -- requirements
Module: func_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (2..16).
REQ-002 The block SHALL have parameter TMO, default 16, giving the cycles allowed for done after start (4..255).
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have port req, input, N, asynchronous four-phase request per requester.
REQ-006 The block SHALL have port ack, output, N, four-phase acknowledge per requester.
REQ-007 The block SHALL have port sel, output, N, one-hot function select to the shared resource.
REQ-008 The block SHALL have port start, output, 1, one-cycle start pulse to the resource.
REQ-009 The block SHALL have port done, input, 1, asynchronous completion level from the resource.
REQ-010 The block SHALL have port gid, output, clog2(N), index of the granted requester.
REQ-011 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 The block SHALL have port err, output, 1, one-cycle pulse on timeout.

Function
REQ-013 Each req bit and done SHALL pass through a 2-flop synchronizer; req_s and done_s denote the synchronized values, with 2-cycle latency.
REQ-014 The state machine SHALL have states IDLE, ISSUE, WAIT, ACK.
REQ-015 In IDLE, when any req_s bit is 1 and done_s is 0, the block SHALL register gid = first set bit at or after ptr, scanning upward with wrap, and move to ISSUE on the next edge.
REQ-016 In IDLE, while done_s is 1, no grant SHALL be issued, because the resource has not yet returned to zero.
REQ-017 In ISSUE, the block SHALL drive sel = onehot(gid) and start = 1 for exactly one cycle, clear the timeout counter, and move to WAIT.
REQ-018 sel SHALL hold from ISSUE until ack[gid] falls; sel SHALL be 0 in IDLE.
REQ-019 In WAIT, on done_s = 1, the block SHALL move to ACK.
REQ-020 In WAIT, when the counter reaches TMO-1 with done_s still 0, the block SHALL pulse err for one cycle and move to ACK.
REQ-021 When done_s and the timeout occur in the same cycle, done SHALL win and err SHALL stay 0.
REQ-022 In ACK, ack[gid] SHALL be 1 and all other ack bits 0.
REQ-023 In ACK, when req_s[gid] = 0, the block SHALL clear ack and sel, set ptr = (gid+1) mod N, and return to IDLE.
REQ-024 req bits that fall before grant SHALL simply not be selected; req bits of non-granted requesters SHALL be ignored until IDLE.
REQ-025 At most one ack bit and at most one sel bit SHALL be high at any time.
REQ-026 The minimum grant-to-grant spacing SHALL be 4 cycles plus synchronizer latency.

Reset
REQ-027 While rst = 1, state SHALL be IDLE, and ptr, gid, ack, sel, start, err, busy, the counter and all synchronizer flops SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL abort the transaction immediately with no err pulse.
REQ-029 After rst deasserts, the first grant SHALL scan from requester 0.

Structure
REQ-030 The state encoding, a clog2 helper function and the TMO counter width SHALL live in the shared package func_pkg.
REQ-031 The 2-flop synchronizer SHALL be a separate sub-module sync2 with async clear, instantiated N+1 times.
REQ-032 The state machine, round-robin scan and counter SHALL reside in func_scheduler itself.

Verification
REQ-033 With N=4, reset, then req=0010 and done returning 1 three cycles after start: the bench SHALL see one start pulse, sel=0010, gid=1, ack=0010 until req drops, then ack=0 and busy=0.
REQ-034 With req=1111 held and each request completed in turn: grants SHALL occur in order 0,1,2,3,0, with no requester granted twice in a row.
REQ-035 With req=0100 and done never asserted, TMO=16: err SHALL pulse exactly once, 16 cycles after start, and ack SHALL be 0100.
REQ-036 With done held at 1 after a transaction while req=0001 is raised again: no start SHALL occur until done is 0, then grant 0.
REQ-037 With rst pulsed during WAIT: ack, sel and busy SHALL be 0 within the same cycle, and the next grant SHALL follow ptr=0 priority.
REQ-038 For every scenario, an assertion SHALL check that sel and ack are each one-hot or zero on every cycle.
